// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle RV64 control unit: FSM states, opcodes,
// datapath mux selects and error codes.
package mcu_pkg;

    typedef enum logic [3:0] {
        BOOT      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        WB_MEM    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        EXEC_I    = 4'd8,
        WB_ALU    = 4'd9,
        BRANCH    = 4'd10,
        ERROR     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_DOUBLE = 3'b011;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_REG   = 2'b01,
        SRC_A_OLDPC = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_REG  = 2'b00,
        SRC_B_FOUR = 2'b01,
        SRC_B_IMM  = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-request wait counter: cleared on entry to a requesting state, flags a
// timeout on the last allowed cycle without mem_ready (MEM_WAIT_MAX=0 disables).
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic busy,
    input  logic mem_ready,
    output logic timeout
);

    localparam int LIMIT = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
    localparam int CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] count;

    // Saturating at LIMIT keeps the counter from wrapping if timeout is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (busy && !mem_ready && (count != CW'(LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = (MEM_WAIT_MAX != 0) && busy && !mem_ready && (count == CW'(LIMIT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV64 datapath (LD, SD, R-type, I-type, BEQ).
// Optional performance counters are enabled with macro MCU_PERF_COUNTERS_EN.
//
// state     | meaning
// BOOT      | one cycle after reset release, all strobes off
// FETCH     | read IR from memory at PC, PC <= PC+4 on completion
// DECODE    | decode opcode, ALUOut <= branch target
// MEM_ADDR  | ALUOut <= regA + imm for LD/SD
// MEM_READ  | data read at ALUOut
// WB_MEM    | rd <= MDR
// MEM_WRITE | data write at ALUOut
// EXEC_R    | ALU regA op regB
// EXEC_I    | ALU regA op imm
// WB_ALU    | rd <= ALUOut
// BRANCH    | compare regA/regB, PC <= ALUOut if equal
// ERROR     | halted until reset, error_code holds the cause
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
`ifdef MCU_PERF_COUNTERS_EN
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count,
`endif
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic [1:0]       error_code,
    output logic [3:0]       state
);

    state_t     state_q, state_d;
    logic [1:0] err_q, err_d;
    logic       timeout;
    logic       timer_start;

    // funct7_5 only matters to the ALU-side decoder that consumes alu_op=10.
    logic unused_funct7_5;
    assign unused_funct7_5 = funct7_5;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            if ((state_d == ERROR) && (state_q != ERROR)) begin
                err_q <= err_d;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = ERR_NONE;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                if ((opcode == OP_LOAD) && (funct3 == F3_DOUBLE)) begin
                    state_d = MEM_ADDR;
                end else if ((opcode == OP_STORE) && (funct3 == F3_DOUBLE)) begin
                    state_d = MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = EXEC_R;
                end else if (opcode == OP_ITYPE) begin
                    state_d = EXEC_I;
                end else if ((opcode == OP_BRANCH) && (funct3 == F3_BEQ)) begin
                    state_d = BRANCH;
                end else begin
                    state_d = ERROR;
                    err_d   = ERR_ILLEGAL;
                end
            end
            MEM_ADDR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                // IR is stable until the next fetch, so the opcode still tells LD from SD.
                state_d   = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_d = WB_MEM;
                end else if (timeout) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            EXEC_R: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_op    = ALU_FUNCT;
                state_d   = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = WB_ALU;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = zero;
                state_d   = FETCH;
            end
            ERROR: halted = 1'b1;
            default: state_d = BOOT;
        endcase
    end

    // A requesting state reached from a different state is always a fresh request.
    assign timer_start = is_mem_state(state_d) && (state_d != state_q);

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (timer_start),
        .busy      (is_mem_state(state_q)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    assign error_code = err_q;
    assign state      = state_q;

`ifdef MCU_PERF_COUNTERS_EN
    logic retire;

    assign retire = (state_d == FETCH) &&
                    ((state_q == WB_MEM) || (state_q == MEM_WRITE) ||
                     (state_q == WB_ALU) || (state_q == BRANCH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if ((state_q != BOOT) && (state_q != ERROR)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (retire) begin
                instret_count <= instret_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences the multicycle RV64 datapath: register file, ALU, immediate generator, PC/IR/ALUOut registers and a shared instruction/data memory port.
- Decodes opcode/funct fields from the IR and drives all datapath enables and mux selects, one phase per cycle.
- Supports LD, SD, R-type, I-type ALU and BEQ.
- Owns the memory request handshake, including a wait timeout.

Parameters:
MEM_WAIT_MAX, 16, max cycles a memory request may wait for mem_ready; 0 disables the timeout
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
clk  in  1  clock; all state changes on rising edge
reset_n  in  1  asynchronous, active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
zero  in  1  ALU zero flag (combinational from the current ALU inputs)
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  request is a write
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR and oldPC from memory data/PC
pc_write  out  1  load PC
pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
alu_src_a  out  2  00=PC, 01=regA, 10=oldPC
alu_src_b  out  2  00=regB, 01=const 4, 10=immediate
alu_op  out  2  00=add, 01=sub, 10=decode from funct
reg_write  out  1  register file write enable
mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR
halted  out  1  sticky; FSM in ERROR state
error_code  out  2  00=none, 01=illegal instruction, 10=memory timeout
state  out  4  debug view of the current state

Behaviour:
- Reset (reset_n low, asynchronous): state=BOOT, every output 0, wait counter 0. BOOT lasts exactly one cycle after release, then goes to FETCH.
- Outputs are decoded from state. pc_write, ir_write and the BRANCH pc_write also depend on mem_ready and zero.
- FETCH:
  - mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (ALUOut = branch target). Next state by opcode:
  - 0000011 with funct3=011 -> MEM_ADDR (load)
  - 0100011 with funct3=011 -> MEM_ADDR (store)
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 with funct3=000 -> BRANCH
  - anything else -> ERROR, error_code=01
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next state is MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: mem_req=1, i_or_d=1. On mem_ready go to WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, then FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, i_or_d=1. On mem_ready go to FETCH.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10, then WB_ALU.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10, then WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero, then FETCH.
- ERROR: all strobes 0, halted=1. Held until reset; error_code is also sticky until reset.
- Latency with zero-wait memory (mem_ready in the first request cycle):
  - R-type, I-type: 4 cycles
  - LD: 5 cycles
  - SD: 4 cycles
  - BEQ: 3 cycles
  - Each wait cycle adds 1.
- Handshake rules:
  - mem_req never drops before mem_ready.
  - mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
  - mem_req is deasserted in the cycle after a completion unless the next state also requests. FETCH directly after MEM_WRITE is a new request.
- Timeout:
  - The wait counter clears whenever the FSM enters a requesting state and increments on each cycle without mem_ready.
  - When MEM_WAIT_MAX≠0 and the count reaches MEM_WAIT_MAX-1 with mem_ready still low, the next state is ERROR with error_code=10.
  - If mem_ready arrives in the same cycle as the limit, the completion wins.
- reset_n asserted mid-instruction: immediate return to BOOT; no partial reg_write or pc_write is emitted after reset is asserted.

Optional Feature:
- Macro MCU_PERF_COUNTERS_EN.
- When defined:
  - Adds output ports cycle_count [CNT_W] and instret_count [CNT_W], both reset to 0.
  - cycle_count increments every cycle outside BOOT and ERROR.
  - instret_count increments on each transition into FETCH from WB_MEM, MEM_WRITE, WB_ALU or BRANCH.
  - Both counters wrap modulo 2^CNT_W.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mcu_pkg:
  - state encoding (BOOT, FETCH, DECODE, MEM_ADDR, MEM_READ, WB_MEM, MEM_WRITE, EXEC_R, EXEC_I, WB_ALU, BRANCH, ERROR)
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH)
  - alu_op, alu_src_a, alu_src_b and error_code encodings
- Sub-module mem_wait_timer: wait counter plus timeout compare, parameterised by MEM_WAIT_MAX.

Test Plan:
- Reset release, opcode=0110011, mem_ready=1 always -> states BOOT, FETCH, DECODE, EXEC_R, WB_ALU, FETCH; reg_write=1 for exactly the WB_ALU cycle; total of 4 cycles per instruction.
- LD (opcode 0000011, funct3=011), mem_ready low for 3 cycles in MEM_READ -> mem_req held for 4 cycles with i_or_d=1; WB_MEM asserts mem_to_reg=1 and reg_write=1; 8 cycles from FETCH to FETCH.
- BEQ (opcode 1100011, funct3=000) with zero=1 -> BRANCH asserts pc_write=1, pc_src=1. With zero=0 -> pc_write=0; 3 cycles in both cases.
- Illegal opcode 1111111 in DECODE -> ERROR, halted=1, error_code=01, all strobes 0; the state persists 100 cycles until a reset_n pulse returns it to BOOT.
- MEM_WAIT_MAX=4, mem_ready held low in FETCH -> ERROR with error_code=10 after 4 request cycles. A second run with mem_ready rising in the 4th cycle -> DECODE, no error.
- reset_n pulled low in the WB_ALU cycle -> reg_write drops asynchronously and the state returns to BOOT. With MCU_PERF_COUNTERS_EN, both counters read 0 after reset, and instret_count=2 after two R-type instructions.
